// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART frame receiver.
//   byte_t / idx_t / len_t / csum_t : data, payload index, length and checksum widths
//   state_t                         : frame controller state encodings
//   SYNC_BYTE_DEF                   : default frame start marker
//   sat_inc8()                      : 8-bit saturating increment
package uart_pkg;

   localparam int IDX_W  = 4;
   localparam int LEN_W  = 5;
   localparam int CSUM_W = 8;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef logic [7:0]        byte_t;
   typedef logic [IDX_W-1:0]  idx_t;
   typedef logic [LEN_W-1:0]  len_t;
   typedef logic [CSUM_W-1:0] csum_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CSUM    = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   function automatic byte_t sat_inc8(input byte_t v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if -- groups the receiver handshake, frame read-out and
// status signals of the frame controller.
//   receiver side : rx_data, rx_valid (to ctrl), rx_clear (from ctrl)
//   consumer side : frame_valid, frame_len, frame_rd_data (from ctrl),
//                   frame_rd_addr, frame_ack (to ctrl)
//   status        : err_csum, err_len, err_timeout, drop_cnt (from ctrl)
// slave  = controller view, master = environment view.
interface uart_rx_frame_ctrl_if;
   import uart_pkg::*;

   byte_t rx_data;
   logic  rx_valid;
   logic  rx_clear;
   logic  frame_valid;
   len_t  frame_len;
   idx_t  frame_rd_addr;
   byte_t frame_rd_data;
   logic  frame_ack;
   logic  err_csum;
   logic  err_len;
   logic  err_timeout;
   byte_t drop_cnt;

   modport slave (
      input  rx_data, rx_valid, frame_rd_addr, frame_ack,
      output rx_clear, frame_valid, frame_len, frame_rd_data,
             err_csum, err_len, err_timeout, drop_cnt
   );

   modport master (
      output rx_data, rx_valid, frame_rd_addr, frame_ack,
      input  rx_clear, frame_valid, frame_len, frame_rd_data,
             err_csum, err_len, err_timeout, drop_cnt
   );

endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf -- payload store, MAX_LEN x 8 registers.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write index, writes outside 0..MAX_LEN-1 are ignored
//   wdata_i : write data
//   raddr_i : read index, combinational read; out-of-range reads return 0
//   rdata_o : read data
module uart_frame_buf
   import uart_pkg::*;
#(
   parameter int MAX_LEN = 16
)(
   input  logic  clk_i,
   input  logic  we_i,
   input  idx_t  waddr_i,
   input  byte_t wdata_i,
   input  idx_t  raddr_i,
   output byte_t rdata_o
);

   byte_t mem_q [MAX_LEN];

   // Contents carry no reset: a frame is only exposed after all of its
   // bytes have been written.
   for (genvar i = 0; i < MAX_LEN; i++) begin : g_entry
      always_ff @(posedge clk_i) begin
         if (we_i && (waddr_i == idx_t'(i))) begin
            mem_q[i] <= wdata_i;
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (raddr_i == idx_t'(i)) begin
            rdata_o = mem_q[i];
         end
      end
   end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl -- assembles SYNC | LEN | PAYLOAD[LEN] | CSUM frames
// from a byte-wide UART receiver and holds a good frame until released.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : uart_rx_frame_ctrl_if.slave (receiver handshake, frame read-out,
//         error pulses, drop counter)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | hunting for SYNC_BYTE, other bytes dropped
// LEN     | waiting for length byte (1..MAX_LEN)
// PAYLOAD | storing payload bytes, accumulating checksum
// CSUM    | waiting for checksum byte; sum of len+payload+csum must be 0
// DONE    | good frame held, receiver back-pressured until frame_ack
module uart_rx_frame_ctrl
   import uart_pkg::*;
#(
   parameter int         CLOCK_FREQ    = 38400000,
   parameter int         BAUD_RATE     = 9600,
   parameter int         MAX_LEN       = 16,
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_BYTES = 4
)(
   input logic           clk,
   input logic           rst,
   uart_rx_frame_ctrl_if.slave bus
);

   localparam int TIMEOUT_CYCLES = (CLOCK_FREQ / BAUD_RATE) * 10 * TIMEOUT_BYTES;
   localparam int TMO_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic             rx_clear_q;
   len_t             frame_len_q, frame_len_d;
   len_t             idx_q, idx_d;
   csum_t            csum_q, csum_d;
   byte_t            drop_q, drop_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_csum_q, err_csum_d;
   logic             err_len_q, err_len_d;
   logic             err_tmo_q, err_tmo_d;

   logic             accept;
   logic             tmo_hit;
   logic             buf_we;
   csum_t            csum_sum;
   byte_t            rd_data;

   // The cycle after an accept has rx_clear high while the receiver is still
   // showing the old byte, so it must not be taken twice.
   assign accept  = bus.rx_valid && !rx_clear_q && (state_q != ST_DONE);
   // An accepted byte always wins over an expiring timer.
   assign tmo_hit = (tmo_q == TMO_LAST) && !accept;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         rx_clear_q  <= 1'b0;
         frame_len_q <= '0;
         idx_q       <= '0;
         csum_q      <= '0;
         drop_q      <= '0;
         tmo_q       <= '0;
         err_csum_q  <= 1'b0;
         err_len_q   <= 1'b0;
         err_tmo_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_clear_q  <= accept;
         frame_len_q <= frame_len_d;
         idx_q       <= idx_d;
         csum_q      <= csum_d;
         drop_q      <= drop_d;
         tmo_q       <= tmo_d;
         err_csum_q  <= err_csum_d;
         err_len_q   <= err_len_d;
         err_tmo_q   <= err_tmo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_len_d = frame_len_q;
      idx_d       = idx_q;
      csum_d      = csum_q;
      drop_d      = drop_q;
      tmo_d       = tmo_q;
      err_csum_d  = 1'b0;
      err_len_d   = 1'b0;
      err_tmo_d   = 1'b0;
      buf_we      = 1'b0;
      csum_sum    = csum_q + csum_t'(bus.rx_data);

      unique case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (accept) begin
               if (bus.rx_data == SYNC_BYTE) begin
                  state_d = ST_LEN;
               end else begin
                  drop_d = sat_inc8(drop_q);
               end
            end
         end

         ST_LEN: begin
            if (accept) begin
               tmo_d = '0;
               if ((bus.rx_data != 8'd0) && (bus.rx_data <= 8'(MAX_LEN))) begin
                  frame_len_d = bus.rx_data[LEN_W-1:0];
                  csum_d      = bus.rx_data;
                  idx_d       = '0;
                  state_d     = ST_PAYLOAD;
               end else begin
                  err_len_d = 1'b1;
                  drop_d    = sat_inc8(drop_q);
                  state_d   = ST_IDLE;
               end
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               tmo_d     = '0;
               state_d   = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         ST_PAYLOAD: begin
            if (accept) begin
               tmo_d  = '0;
               buf_we = 1'b1;
               csum_d = csum_sum;
               idx_d  = idx_q + 5'd1;
               if ((idx_q + 5'd1) == frame_len_q) begin
                  state_d = ST_CSUM;
               end
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               tmo_d     = '0;
               state_d   = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         ST_CSUM: begin
            if (accept) begin
               tmo_d = '0;
               if (csum_sum == '0) begin
                  state_d = ST_DONE;
               end else begin
                  err_csum_d = 1'b1;
                  state_d    = ST_IDLE;
               end
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               tmo_d     = '0;
               state_d   = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         ST_DONE: begin
            tmo_d = '0;
            if (bus.frame_ack) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            tmo_d   = '0;
         end
      endcase
   end

   uart_frame_buf #(
      .MAX_LEN (MAX_LEN)
   ) u_buf (
      .clk_i   (clk),
      .we_i    (buf_we),
      .waddr_i (idx_q[IDX_W-1:0]),
      .wdata_i (bus.rx_data),
      .raddr_i (bus.frame_rd_addr),
      .rdata_o (rd_data)
   );

   assign bus.rx_clear      = rx_clear_q;
   assign bus.frame_valid   = (state_q == ST_DONE);
   assign bus.frame_len     = frame_len_q;
   assign bus.frame_rd_data = rd_data;
   assign bus.err_csum      = err_csum_q;
   assign bus.err_len       = err_len_q;
   assign bus.err_timeout   = err_tmo_q;
   assign bus.drop_cnt      = drop_q;

endmodule
